grad_dac_spi: RTL and testbench
===============================

Name: grad_dac_spi

Overview:
- Serialises 32-bit gradient words from the gradient BRAM stage (data_o/valid_o) into SPI frames for the four-channel gradient DAC.
- Sits directly downstream of the BRAM readout and feeds its busy flag back into that stage's serial_busy_i input.
- Holds one word of buffering, reports overruns, and takes its SCLK divisor from the BRAM stage's spi_clk_div_o register.

Parameters:
- FRAME_BITS, 24, SPI bits per frame, taken from data_i[FRAME_BITS-1:0] and sent MSB first.
- N_CS, 4, number of chip-select lines, indexed by data_i[25:24].

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, synchronous, active-high.
- data_i  input  32  word from the BRAM stage; [23:0] is the DAC payload, [25:24] is the channel, [31:26] are ignored.
- valid_i  input  1  single-cycle strobe; data_i is valid when this is high.
- spi_clk_div_i  input  6  SCLK half-period minus one, in clk_i cycles.
- busy_o  output  1  high while a frame is active or a word is pending; drives the upstream serial_busy_i.
- overrun_o  output  1  sticky; set when a word is dropped.
- sclk_o  output  1  SPI clock, CPOL=0.
- mosi_o  output  1  SPI data; changes on the SCLK falling edge and is held stable around the rising edge.
- cs_n_o  output  4  active-low chip selects, one-hot low during a frame.

Behaviour:
- Reset (rst_i high at a clk_i edge) sets on the next cycle:
  - sclk_o=0, mosi_o=0, cs_n_o=4'hF, busy_o=0, overrun_o=0.
  - Pending buffer empty, state IDLE.
  - Reset mid-frame aborts the frame immediately; no partial-frame completion.
- H = spi_clk_div_i+1 cycles.
  - Latched together with the word at frame launch.
  - Changes to spi_clk_div_i mid-frame have no effect until the next launch.
- Accept rules:
  - valid_i high in IDLE with pending empty: word launches and goes straight into the shift register.
  - valid_i high while a frame is active and pending is empty: word is stored in pending.
  - valid_i high while pending is full: word is dropped and overrun_o set (sticky until reset); the active frame and the pending word are untouched.
- States: IDLE -> SETUP -> SHIFT -> GAP -> IDLE, or GAP -> SETUP if pending is full.
  - Launch edge T, registered outputs from T+1.
  - SETUP, H cycles: cs_n_o[ch] low, mosi_o = bit 23, sclk_o=0.
  - SHIFT, 24 bits: for each bit, sclk_o high for H cycles, then low for H cycles. On each high-to-low transition mosi_o advances to the next bit. After the 24th falling edge mosi_o holds bit 0 for that final low phase (the DAC hold time).
  - GAP, H cycles: cs_n_o=4'hF, sclk_o=0, mosi_o=0.
  - Leaving GAP:
    - Pending full: load pending into the shift register, empty the buffer, go to SETUP (cs_n_o low on the very next cycle).
    - Pending empty: go to IDLE.
- Frame length is SETUP H + SHIFT 48H + GAP H = 50H cycles.
- busy_o:
  - Rises at T+1.
  - Falls in the first IDLE cycle when pending is empty.
  - A strobe in the same cycle as the GAP-to-IDLE transition is treated as an IDLE accept: busy_o stays high with no low cycle.
- rst_i and valid_i in the same cycle: reset wins and the word is discarded.
- Only bits [25:24] select the channel; no other field of data_i affects the chip selects.

Test Plan:
- div=0, strobe data=0x00A5A5A5 (ch0):
  - cs_n_o=4'b1110 for exactly 49 cycles; 24 SCLK pulses, 1 cycle high and 1 cycle low each.
  - MOSI sampled at the rising edges = 0xA5A5A5.
  - busy_o high for exactly 50 cycles.
- div=30, data=0x02ABCDEF (ch2):
  - cs_n_o=4'b1011; SCLK high and low phases of 31 cycles each.
  - busy_o high for 1550 cycles; sampled bits = 0xABCDEF.
- div=0, two strobes 3 cycles apart (0x00000001, then 0x01FFFFFF):
  - Second word launches immediately after the first GAP.
  - busy_o high continuously for 100 cycles; overrun_o stays 0.
  - Second frame uses cs_n_o=4'b1101.
- div=0, three strobes within one frame:
  - Third word is dropped; overrun_o=1 and stays 1.
  - Exactly two frames are emitted, with payloads equal to the first and second words.
- div=5, change spi_clk_div_i to 0 at cycle 20 of the frame:
  - Frame keeps H=6 throughout (300 cycles).
  - The next launched frame uses H=1.
- Pulse rst_i at cycle 30 of a div=2 frame with a pending word:
  - Next cycle: cs_n_o=4'hF, sclk_o=0, busy_o=0, overrun_o=0.
  - The pending word is never sent.

Source files
------------

// File: rtl/grad_dac_spi.sv
// rtl/grad_dac_spi.sv - gradient word to four-channel DAC SPI serialiser with one-word pending buffer
module grad_dac_spi #(
    parameter int FRAME_BITS = 24,
    parameter int N_CS       = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     data_i,
    input  logic            valid_i,
    input  logic [5:0]      spi_clk_div_i,
    output logic            busy_o,
    output logic            overrun_o,
    output logic            sclk_o,
    output logic            mosi_o,
    output logic [N_CS-1:0] cs_n_o
);
    localparam int CH_W   = $clog2(N_CS);
    localparam int BIT_W  = $clog2(FRAME_BITS);
    localparam int WORD_W = FRAME_BITS + CH_W;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;

    state_t              r_state, w_state_nx;
    logic [FRAME_BITS-1:0] r_shift, w_shift_nx;
    logic [5:0]          r_div, w_div_nx;
    logic [5:0]          r_cnt, w_cnt_nx;
    logic [BIT_W-1:0]    r_bit, w_bit_nx;
    logic                r_pend_valid, w_pend_valid_nx;
    logic [WORD_W-1:0]   r_pend, w_pend_nx;
    logic                r_sclk, w_sclk_nx;
    logic                r_mosi, w_mosi_nx;
    logic                r_busy, w_busy_nx;
    logic                r_overrun, w_overrun_nx;
    logic [N_CS-1:0]     r_cs_n, w_cs_n_nx;

    logic                w_cnt_done;
    logic                w_launch;
    logic                w_take_input;
    logic [WORD_W-1:0]   w_launch_word;
    logic                w_unused;

    assign w_cnt_done = (r_cnt == r_div);
    assign w_unused   = ^data_i[31:WORD_W];

    always_comb begin
        w_state_nx      = r_state;
        w_shift_nx      = r_shift;
        w_div_nx        = r_div;
        w_cnt_nx        = r_cnt;
        w_bit_nx        = r_bit;
        w_pend_valid_nx = r_pend_valid;
        w_pend_nx       = r_pend;
        w_sclk_nx       = r_sclk;
        w_mosi_nx       = r_mosi;
        w_busy_nx       = r_busy;
        w_overrun_nx    = r_overrun;
        w_cs_n_nx       = r_cs_n;
        w_launch        = 1'b0;
        w_take_input    = 1'b0;
        w_launch_word   = data_i[WORD_W-1:0];

        case (r_state)
            S_IDLE: begin
                if (valid_i) begin
                    w_launch     = 1'b1;
                    w_take_input = 1'b1;
                end
            end
            S_SETUP: begin
                w_cnt_nx = r_cnt + 6'd1;
                if (w_cnt_done) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_SHIFT;
                    w_sclk_nx  = 1'b1;
                    w_bit_nx   = '0;
                end
            end
            S_SHIFT: begin
                w_cnt_nx = r_cnt + 6'd1;
                if (w_cnt_done) begin
                    w_cnt_nx = '0;
                    if (r_sclk) begin
                        w_sclk_nx = 1'b0;
                        // The last bit stays on MOSI through its low phase as DAC hold time.
                        if (r_bit != LAST_BIT) begin
                            w_shift_nx = {r_shift[FRAME_BITS-2:0], 1'b0};
                            w_mosi_nx  = r_shift[FRAME_BITS-2];
                        end
                    end else if (r_bit == LAST_BIT) begin
                        w_state_nx = S_GAP;
                        w_cs_n_nx  = '1;
                        w_mosi_nx  = 1'b0;
                    end else begin
                        w_bit_nx  = r_bit + BIT_W'(1);
                        w_sclk_nx = 1'b1;
                    end
                end
            end
            S_GAP: begin
                w_cnt_nx = r_cnt + 6'd1;
                if (w_cnt_done) begin
                    w_cnt_nx = '0;
                    if (r_pend_valid) begin
                        w_launch        = 1'b1;
                        w_launch_word   = r_pend;
                        w_pend_valid_nx = 1'b0;
                    end else if (valid_i) begin
                        w_launch     = 1'b1;
                        w_take_input = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_busy_nx  = 1'b0;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // A strobe not consumed by a launch goes to the pending slot, or is dropped if it is occupied.
        if (valid_i && !w_take_input) begin
            if (r_pend_valid) begin
                w_overrun_nx = 1'b1;
            end else begin
                w_pend_nx       = data_i[WORD_W-1:0];
                w_pend_valid_nx = 1'b1;
            end
        end

        if (w_launch) begin
            w_state_nx = S_SETUP;
            w_shift_nx = w_launch_word[FRAME_BITS-1:0];
            w_div_nx   = spi_clk_div_i;
            w_cnt_nx   = '0;
            w_bit_nx   = '0;
            w_cs_n_nx  = ~(N_CS'(1) << w_launch_word[FRAME_BITS +: CH_W]);
            w_mosi_nx  = w_launch_word[FRAME_BITS-1];
            w_sclk_nx  = 1'b0;
            w_busy_nx  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_div        <= '0;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_pend_valid <= 1'b0;
            r_pend       <= '0;
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            r_cs_n       <= '1;
        end else begin
            r_state      <= w_state_nx;
            r_shift      <= w_shift_nx;
            r_div        <= w_div_nx;
            r_cnt        <= w_cnt_nx;
            r_bit        <= w_bit_nx;
            r_pend_valid <= w_pend_valid_nx;
            r_pend       <= w_pend_nx;
            r_sclk       <= w_sclk_nx;
            r_mosi       <= w_mosi_nx;
            r_busy       <= w_busy_nx;
            r_overrun    <= w_overrun_nx;
            r_cs_n       <= w_cs_n_nx;
        end
    end

    assign busy_o    = r_busy;
    assign overrun_o = r_overrun;
    assign sclk_o    = r_sclk;
    assign mosi_o    = r_mosi;
    assign cs_n_o    = r_cs_n;

endmodule

// File: tb/tb_grad_dac_spi.sv
// tb/tb_grad_dac_spi.sv - directed bench for grad_dac_spi with an SPI frame monitor
module tb_grad_dac_spi;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic [5:0]  spi_clk_div_i;
    logic        busy_o, overrun_o, sclk_o, mosi_o;
    logic [3:0]  cs_n_o;

    int n_vec = 0;
    int n_err = 0;

    grad_dac_spi #(.FRAME_BITS(24), .N_CS(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
        .spi_clk_div_i(spi_clk_div_i), .busy_o(busy_o), .overrun_o(overrun_o),
        .sclk_o(sclk_o), .mosi_o(mosi_o), .cs_n_o(cs_n_o)
    );

    always #5 clk_i = ~clk_i;

    // Frame monitor: records payload, chip select, lengths and SCLK phase extremes per frame.
    int          n_frames = 0;
    int          n_busy = 0;
    logic [23:0] f_data [16];
    logic [3:0]  f_cs [16];
    int          f_bits [16], f_cslen [16], f_himin [16], f_himax [16], f_lomin [16], f_lomax [16];
    int          b_len [16];
    logic        p_sclk = 1'b0, p_busy = 1'b0, in_frame = 1'b0;
    logic [3:0]  p_cs = 4'hF, cur_cs = 4'hF;
    logic [23:0] cur_data = '0;
    int          cs_len = 0, cur_bits = 0, hi_run = 0, lo_run = 0, busy_run = 0;
    int          hmin = 0, hmax = 0, lmin = 0, lmax = 0;

    always @(negedge clk_i) begin
        p_sclk <= sclk_o;
        p_cs   <= cs_n_o;
        p_busy <= busy_o;
        if (rst_i) begin
            in_frame <= 1'b0;
            busy_run <= 0;
        end else begin
            if (busy_o) begin
                busy_run <= busy_run + 1;
            end else if (p_busy && busy_run > 0) begin
                if (n_busy < 16) b_len[n_busy] <= busy_run;
                n_busy   <= n_busy + 1;
                busy_run <= 0;
            end
            if (cs_n_o != 4'hF && p_cs == 4'hF) begin
                in_frame <= 1'b1;
                cur_cs   <= cs_n_o;
                cs_len   <= 1;
                cur_bits <= 0;
                cur_data <= '0;
                hi_run   <= 0;
                lo_run   <= 0;
                hmin <= 9999; hmax <= 0; lmin <= 9999; lmax <= 0;
            end else if (cs_n_o != 4'hF && in_frame) begin
                cs_len <= cs_len + 1;
                if (sclk_o && !p_sclk) begin
                    cur_bits <= cur_bits + 1;
                    cur_data <= {cur_data[22:0], mosi_o};
                    hi_run   <= 1;
                    lo_run   <= 0;
                    if (lo_run > 0) begin
                        lmin <= (lo_run < lmin) ? lo_run : lmin;
                        lmax <= (lo_run > lmax) ? lo_run : lmax;
                    end
                end else if (sclk_o) begin
                    hi_run <= hi_run + 1;
                end else if (p_sclk) begin
                    hmin   <= (hi_run < hmin) ? hi_run : hmin;
                    hmax   <= (hi_run > hmax) ? hi_run : hmax;
                    lo_run <= 1;
                end else if (lo_run > 0) begin
                    lo_run <= lo_run + 1;
                end
            end else if (cs_n_o == 4'hF && in_frame) begin
                if (n_frames < 16) begin
                    f_data[n_frames]  <= cur_data;
                    f_cs[n_frames]    <= cur_cs;
                    f_bits[n_frames]  <= cur_bits;
                    f_cslen[n_frames] <= cs_len;
                    f_himin[n_frames] <= hmin;
                    f_himax[n_frames] <= hmax;
                    f_lomin[n_frames] <= (lo_run < lmin) ? lo_run : lmin;
                    f_lomax[n_frames] <= (lo_run > lmax) ? lo_run : lmax;
                end
                n_frames <= n_frames + 1;
                in_frame <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic strobe(input logic [31:0] d);
        data_i  = d;
        valid_i = 1'b1;
        step(1);
        valid_i = 1'b0;
    endtask

    task automatic wait_busy(input int target, input int budget);
        int k;
        k = 0;
        while (n_busy < target && k < budget) begin
            step(1);
            k++;
        end
        step(2);
        check("busy_fall_timeout", n_busy, target);
    endtask

    task automatic check_frame(input string tag, input int i, input logic [23:0] d, input logic [3:0] cs,
                               input int cslen, input int h);
        check({tag, "_data"}, f_data[i], d);
        check({tag, "_cs"}, f_cs[i], cs);
        check({tag, "_bits"}, f_bits[i], 24);
        check({tag, "_cslen"}, f_cslen[i], cslen);
        check({tag, "_himin"}, f_himin[i], h);
        check({tag, "_himax"}, f_himax[i], h);
        check({tag, "_lomin"}, f_lomin[i], h);
        check({tag, "_lomax"}, f_lomax[i], h);
    endtask

    initial begin
        int fb, bb;
        rst_i = 1'b1;
        valid_i = 1'b0;
        data_i = '0;
        spi_clk_div_i = 6'd0;
        step(2);
        check("rst_sclk", sclk_o, 0);
        check("rst_mosi", mosi_o, 0);
        check("rst_cs", cs_n_o, 4'hF);
        check("rst_busy", busy_o, 0);
        check("rst_ovr", overrun_o, 0);
        rst_i = 1'b0;
        step(3);

        // div=0, single frame on channel 0
        fb = n_frames; bb = n_busy;
        strobe(32'h00A5A5A5);
        check("t1_busy_rise", busy_o, 1);
        check("t1_cs_rise", cs_n_o, 4'hE);
        check("t1_mosi_b23", mosi_o, 1);
        wait_busy(bb + 1, 200);
        check_frame("t1", fb, 24'hA5A5A5, 4'hE, 49, 1);
        check("t1_busy_len", b_len[bb], 50);
        check("t1_ovr", overrun_o, 0);

        // div=30, channel 2
        spi_clk_div_i = 6'd30;
        fb = n_frames; bb = n_busy;
        strobe(32'h02ABCDEF);
        wait_busy(bb + 1, 2000);
        check_frame("t2", fb, 24'hABCDEF, 4'hB, 49 * 31, 31);
        check("t2_busy_len", b_len[bb], 1550);

        // div=0, second word arrives mid-frame and launches right after the gap
        spi_clk_div_i = 6'd0;
        fb = n_frames; bb = n_busy;
        strobe(32'h00000001);
        step(2);
        strobe(32'h01FFFFFF);
        wait_busy(bb + 1, 300);
        check("t3_nframes", n_frames - fb, 2);
        check_frame("t3a", fb, 24'h000001, 4'hE, 49, 1);
        check_frame("t3b", fb + 1, 24'hFFFFFF, 4'hD, 49, 1);
        check("t3_busy_len", b_len[bb], 100);
        check("t3_ovr", overrun_o, 0);

        // div=0, three strobes in one frame: third is dropped
        fb = n_frames; bb = n_busy;
        strobe(32'h00123456);
        step(4);
        strobe(32'h03654321);
        step(4);
        strobe(32'h02DEAD00);
        check("t4_ovr_set", overrun_o, 1);
        wait_busy(bb + 1, 300);
        step(60);
        check("t4_nframes", n_frames - fb, 2);
        check("t4a_data", f_data[fb], 24'h123456);
        check("t4b_data", f_data[fb + 1], 24'h654321);
        check("t4b_cs", f_cs[fb + 1], 4'h7);
        check("t4_ovr_sticky", overrun_o, 1);

        // div=5, divisor changed mid-frame; pending word picks up the new one at its launch
        spi_clk_div_i = 6'd5;
        fb = n_frames; bb = n_busy;
        strobe(32'h01000F0F);
        step(18);
        spi_clk_div_i = 6'd0;
        step(20);
        strobe(32'h00F0F0F0);
        wait_busy(bb + 1, 800);
        check_frame("t5a", fb, 24'h000F0F, 4'hD, 49 * 6, 6);
        check_frame("t5b", fb + 1, 24'hF0F0F0, 4'hE, 49, 1);
        check("t5_busy_len", b_len[bb], 350);

        // div=2, reset mid-frame with a pending word and a simultaneous strobe
        spi_clk_div_i = 6'd2;
        fb = n_frames;
        strobe(32'h00FFFF00);
        step(3);
        strobe(32'h01AAAAAA);
        step(24);
        rst_i = 1'b1;
        valid_i = 1'b1;
        data_i = 32'h03123456;
        step(1);
        rst_i = 1'b0;
        valid_i = 1'b0;
        check("t6_cs", cs_n_o, 4'hF);
        check("t6_sclk", sclk_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_ovr", overrun_o, 0);
        check("t6_mosi", mosi_o, 0);
        step(400);
        check("t6_nframes", n_frames - fb, 0);
        check("t6_busy_late", busy_o, 0);
        check("t6_cs_late", cs_n_o, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
